// File: rtl/drac_pkg.sv
// Shared Lagarto/DRAC definitions: instruction types, CSR commands and
// the CSR request sequencer state encoding.
package drac_pkg;

  localparam logic [6:0] INSTR_ECALL      = 7'd23;
  localparam logic [6:0] INSTR_EBREAK     = 7'd24;
  localparam logic [6:0] INSTR_URET       = 7'd25;
  localparam logic [6:0] INSTR_SRET       = 7'd26;
  localparam logic [6:0] INSTR_MRET       = 7'd27;
  localparam logic [6:0] INSTR_WFI        = 7'd28;
  localparam logic [6:0] INSTR_FENCE      = 7'd29;
  localparam logic [6:0] INSTR_FENCE_TSO  = 7'd30;
  localparam logic [6:0] INSTR_FENCE_I    = 7'd31;
  localparam logic [6:0] INSTR_PAUSE      = 7'd32;
  localparam logic [6:0] INSTR_SFENCE_VMA = 7'd33;
  localparam logic [6:0] INSTR_HFENCE_V   = 7'd34;
  localparam logic [6:0] INSTR_HFENCE_G   = 7'd35;
  localparam logic [6:0] INSTR_CSRRW      = 7'd36;
  localparam logic [6:0] INSTR_CSRRS      = 7'd37;
  localparam logic [6:0] INSTR_CSRRC      = 7'd38;
  localparam logic [6:0] INSTR_CSRRWI     = 7'd39;
  localparam logic [6:0] INSTR_CSRRSI     = 7'd40;
  localparam logic [6:0] INSTR_CSRRCI     = 7'd41;

  typedef enum logic [2:0] {
    CSR_CMD_NOP    = 3'b000,
    CSR_CMD_WRITE  = 3'b001,
    CSR_CMD_SET    = 3'b010,
    CSR_CMD_CLEAR  = 3'b011,
    CSR_CMD_SYSTEM = 3'b100,
    CSR_CMD_READ   = 3'b101
  } csr_cmd_t;

  typedef enum logic [1:0] {
    CSR_IDLE,
    CSR_REQ,
    CSR_WAIT,
    CSR_DONE
  } csr_state_t;

endpackage

// File: rtl/csr_decode.sv
// Combinational decode of the WB instruction type into a CSR command and operand.
module csr_decode
  import drac_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [6:0]      instr_type_i,
  input  logic [4:0]      rs1_i,
  input  logic [XLEN-1:0] rs1_data_i,
  output logic            is_csr_o,
  output csr_cmd_t        cmd_o,
  output logic [XLEN-1:0] operand_o
);

  logic [XLEN-1:0] zimm;
  logic            rs1_zero;

  assign zimm     = {{(XLEN-5){1'b0}}, rs1_i};
  assign rs1_zero = (rs1_i == '0);

  always_comb begin
    is_csr_o  = 1'b1;
    cmd_o     = CSR_CMD_NOP;
    operand_o = '0;
    case (instr_type_i)
      INSTR_CSRRW: begin
        cmd_o     = CSR_CMD_WRITE;
        operand_o = rs1_data_i;
      end
      INSTR_CSRRWI: begin
        cmd_o     = CSR_CMD_WRITE;
        operand_o = zimm;
      end
      INSTR_CSRRS: begin
        cmd_o     = rs1_zero ? CSR_CMD_READ : CSR_CMD_SET;
        operand_o = rs1_data_i;
      end
      INSTR_CSRRSI: begin
        cmd_o     = rs1_zero ? CSR_CMD_READ : CSR_CMD_SET;
        operand_o = zimm;
      end
      INSTR_CSRRC: begin
        cmd_o     = rs1_zero ? CSR_CMD_READ : CSR_CMD_CLEAR;
        operand_o = rs1_data_i;
      end
      INSTR_CSRRCI: begin
        cmd_o     = rs1_zero ? CSR_CMD_READ : CSR_CMD_CLEAR;
        operand_o = zimm;
      end
      INSTR_ECALL, INSTR_EBREAK, INSTR_URET, INSTR_SRET,
      INSTR_MRET, INSTR_WFI, INSTR_FENCE_I, INSTR_SFENCE_VMA: begin
        cmd_o = CSR_CMD_SYSTEM;
      end
      default: is_csr_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/csr_req_unit.sv
// Write-back CSR request sequencer: issues one CSR command over valid/ready,
// waits for the response (bounded by a timeout) and stalls WB meanwhile.
module csr_req_unit
  import drac_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned CSR_ADDR_W     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  stall_exe_i,
  input  logic                  wb_valid_i,
  input  logic                  wb_xcpt_i,
  input  logic [6:0]            wb_instr_type_i,
  input  logic [4:0]            wb_rs1_i,
  input  logic [XLEN-1:0]       wb_rs1_data_i,
  input  logic [CSR_ADDR_W-1:0] wb_csr_addr_i,
  input  logic [XLEN-1:0]       wb_pc_i,
  output logic                  csr_req_valid_o,
  input  logic                  csr_req_ready_i,
  output logic [CSR_ADDR_W-1:0] csr_req_addr_o,
  output logic [2:0]            csr_req_cmd_o,
  output logic [XLEN-1:0]       csr_req_data_o,
  output logic [XLEN-1:0]       csr_req_pc_o,
  input  logic                  csr_resp_valid_i,
  input  logic [XLEN-1:0]       csr_resp_data_i,
  input  logic                  csr_resp_xcpt_i,
  output logic                  wb_stall_o,
  output logic                  wb_csr_done_o,
  output logic [XLEN-1:0]       wb_csr_rdata_o,
  output logic                  wb_csr_xcpt_o,
  output logic                  retire_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  // WAIT lasts TIMEOUT_CYCLES-1 cycles: timeout fires when the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  csr_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic            discard;
  logic            is_csr;
  csr_cmd_t        dec_cmd;
  logic [XLEN-1:0] dec_operand;
  logic            accept;

  csr_decode #(.XLEN(XLEN)) u_decode (
    .instr_type_i (wb_instr_type_i),
    .rs1_i        (wb_rs1_i),
    .rs1_data_i   (wb_rs1_data_i),
    .is_csr_o     (is_csr),
    .cmd_o        (dec_cmd),
    .operand_o    (dec_operand)
  );

  // Accept is gated by IDLE so the instruction still sitting in WB during DONE is not re-issued.
  assign accept     = (state == CSR_IDLE) & wb_valid_i & is_csr & ~wb_xcpt_i
                      & ~flush_i & ~stall_exe_i;
  assign wb_stall_o = accept | (state == CSR_REQ) | (state == CSR_WAIT);
  assign retire_o   = wb_valid_i & ~wb_xcpt_i & ~stall_exe_i & ~is_csr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= CSR_IDLE;
      cnt             <= '0;
      discard         <= 1'b0;
      csr_req_valid_o <= 1'b0;
      csr_req_addr_o  <= '0;
      csr_req_cmd_o   <= '0;
      csr_req_data_o  <= '0;
      csr_req_pc_o    <= '0;
      wb_csr_done_o   <= 1'b0;
      wb_csr_rdata_o  <= '0;
      wb_csr_xcpt_o   <= 1'b0;
    end else begin
      wb_csr_done_o <= 1'b0;
      unique case (state)
        CSR_IDLE: begin
          if (accept) begin
            state           <= CSR_REQ;
            csr_req_valid_o <= 1'b1;
            csr_req_addr_o  <= wb_csr_addr_i;
            csr_req_cmd_o   <= dec_cmd;
            csr_req_data_o  <= dec_operand;
            csr_req_pc_o    <= wb_pc_i;
          end
        end
        CSR_REQ: begin
          if (csr_req_ready_i) begin
            state           <= CSR_WAIT;
            csr_req_valid_o <= 1'b0;
            cnt             <= '0;
            discard         <= flush_i;
          end else if (flush_i) begin
            state           <= CSR_IDLE;
            csr_req_valid_o <= 1'b0;
          end
        end
        CSR_WAIT: begin
          cnt     <= cnt + 1'b1;
          discard <= discard | flush_i;
          if (csr_resp_valid_i) begin
            state          <= CSR_DONE;
            wb_csr_rdata_o <= csr_resp_data_i;
            wb_csr_xcpt_o  <= csr_resp_xcpt_i;
            wb_csr_done_o  <= ~(discard | flush_i);
          end else if (cnt == CNT_LAST) begin
            state          <= CSR_DONE;
            wb_csr_rdata_o <= '0;
            wb_csr_xcpt_o  <= 1'b1;
            wb_csr_done_o  <= ~(discard | flush_i);
          end
        end
        CSR_DONE: begin
          state   <= CSR_IDLE;
          discard <= 1'b0;
        end
        default: state <= CSR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_req_unit.sv
// Randomized self-checking bench for csr_req_unit against a transaction-level model.
module tb_csr_req_unit;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i, stall_exe_i, wb_valid_i, wb_xcpt_i;
  logic [6:0]  wb_instr_type_i;
  logic [4:0]  wb_rs1_i;
  logic [63:0] wb_rs1_data_i, wb_pc_i;
  logic [11:0] wb_csr_addr_i;
  logic        csr_req_valid_o, csr_req_ready_i;
  logic [11:0] csr_req_addr_o;
  logic [2:0]  csr_req_cmd_o;
  logic [63:0] csr_req_data_o, csr_req_pc_o;
  logic        csr_resp_valid_i, csr_resp_xcpt_i;
  logic [63:0] csr_resp_data_i;
  logic        wb_stall_o, wb_csr_done_o, wb_csr_xcpt_o, retire_o;
  logic [63:0] wb_csr_rdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  csr_req_unit #(.XLEN(64), .CSR_ADDR_W(12), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_exe_i(stall_exe_i),
    .wb_valid_i(wb_valid_i), .wb_xcpt_i(wb_xcpt_i), .wb_instr_type_i(wb_instr_type_i),
    .wb_rs1_i(wb_rs1_i), .wb_rs1_data_i(wb_rs1_data_i), .wb_csr_addr_i(wb_csr_addr_i),
    .wb_pc_i(wb_pc_i), .csr_req_valid_o(csr_req_valid_o), .csr_req_ready_i(csr_req_ready_i),
    .csr_req_addr_o(csr_req_addr_o), .csr_req_cmd_o(csr_req_cmd_o),
    .csr_req_data_o(csr_req_data_o), .csr_req_pc_o(csr_req_pc_o),
    .csr_resp_valid_i(csr_resp_valid_i), .csr_resp_data_i(csr_resp_data_i),
    .csr_resp_xcpt_i(csr_resp_xcpt_i), .wb_stall_o(wb_stall_o),
    .wb_csr_done_o(wb_csr_done_o), .wb_csr_rdata_o(wb_csr_rdata_o),
    .wb_csr_xcpt_o(wb_csr_xcpt_o), .retire_o(retire_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_cmd(input int t, input int r);
    if (t == 36 || t == 39) return 3'b001;
    if (t == 37 || t == 40) return (r == 0) ? 3'b101 : 3'b010;
    if (t == 38 || t == 41) return (r == 0) ? 3'b101 : 3'b011;
    if ((t >= 23 && t <= 28) || t == 31 || t == 33) return 3'b100;
    return 3'b000;
  endfunction

  function automatic bit ref_is_csr(input int t);
    return ref_cmd(t, 1) != 3'b000;
  endfunction

  function automatic logic [63:0] ref_data(input int t, input int r, input logic [63:0] d);
    if (t >= 36 && t <= 38) return d;
    if (t >= 39 && t <= 41) return 64'(r);
    return 64'd0;
  endfunction

  function automatic int rand_csr_type();
    int idx;
    idx = int'($urandom_range(0, 13));
    if (idx < 6)  return 36 + idx;
    if (idx < 12) return 23 + idx - 6;
    return (idx == 12) ? 31 : 33;
  endfunction

  task automatic quiet();
    flush_i = 0; stall_exe_i = 0; wb_valid_i = 0; wb_xcpt_i = 0;
    wb_instr_type_i = '0; wb_rs1_i = '0; wb_rs1_data_i = '0; wb_csr_addr_i = '0; wb_pc_i = '0;
    csr_req_ready_i = 0; csr_resp_valid_i = 0; csr_resp_data_i = '0; csr_resp_xcpt_i = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 64'(csr_req_valid_o), 64'd0);
    check({tag, ".stall"}, 64'(wb_stall_o), 64'd0);
    check({tag, ".done"},  64'(wb_csr_done_o), 64'd0);
  endtask

  // Non-CSR traffic, and CSR traffic that must not be accepted; stray responses are ignored.
  task automatic filler(input int n);
    for (int c = 0; c < n; c++) begin
      int t; bit v, x, s, f;
      t = int'($urandom_range(0, 127));
      v = ($urandom_range(0, 3) != 0);
      x = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 5) == 0);
      if (v && ref_is_csr(t) && !x && !s && !f) x = 1;
      wb_valid_i = v; wb_xcpt_i = x; stall_exe_i = s; flush_i = f;
      wb_instr_type_i = 7'(t); wb_rs1_i = 5'($urandom); wb_rs1_data_i = {$urandom, $urandom};
      csr_resp_valid_i = ($urandom_range(0, 3) == 0); csr_resp_data_i = {$urandom, $urandom};
      @(negedge clk_i);
      check("fill.retire", 64'(retire_o), 64'(v && !x && !s && !ref_is_csr(t)));
      check_idle("fill");
      next_cycle();
    end
    quiet();
  endtask

  // fmode: 0 none, 1 flush in REQ without ready, 2 flush with ready, 3 flush in WAIT.
  // k: WAIT cycle index at which the CSR file responds (>= TO-1 means never).
  task automatic run_csr(input int typ, input int rs1, input logic [63:0] rs1d,
                         input logic [11:0] addr, input logic [63:0] pc,
                         input int rdly, input int k, input int fmode, input int fidx,
                         input logic [63:0] rdv, input bit rx);
    logic [2:0]  ecmd;
    logic [63:0] edata;
    int  hs, wl;
    bit  timeout, discard, flushed;
    ecmd  = ref_cmd(typ, rs1);
    edata = ref_data(typ, rs1, rs1d);
    wl      = (k < TO - 1) ? k + 1 : TO - 1;
    timeout = (k >= TO - 1);
    discard = (fmode == 2) || (fmode == 3);
    hs = 0; flushed = 0;

    quiet();
    wb_valid_i = 1; wb_instr_type_i = 7'(typ); wb_rs1_i = 5'(rs1);
    wb_rs1_data_i = rs1d; wb_csr_addr_i = addr; wb_pc_i = pc;
    csr_resp_valid_i = ($urandom_range(0, 1) == 1);
    @(negedge clk_i);
    check("acc.stall", 64'(wb_stall_o), 64'd1);
    check("acc.valid", 64'(csr_req_valid_o), 64'd0);
    check("acc.retire", 64'(retire_o), 64'd0);
    next_cycle();
    csr_resp_valid_i = 0;

    for (int i = 0; i <= rdly; i++) begin
      csr_req_ready_i = (fmode != 1) && (i == rdly);
      flush_i = ((fmode == 1) && (i == fidx)) || ((fmode == 2) && (i == rdly));
      @(negedge clk_i);
      check("req.valid", 64'(csr_req_valid_o), 64'd1);
      check("req.addr",  64'(csr_req_addr_o), 64'(addr));
      check("req.cmd",   64'(csr_req_cmd_o), 64'(ecmd));
      check("req.data",  csr_req_data_o, edata);
      check("req.pc",    csr_req_pc_o, pc);
      check("req.stall", 64'(wb_stall_o), 64'd1);
      if (csr_req_valid_o && csr_req_ready_i) hs++;
      next_cycle();
      if (fmode == 1 && i == fidx) begin
        flushed = 1;
        break;
      end
    end
    csr_req_ready_i = 0; flush_i = 0;

    if (flushed) begin
      wb_valid_i = 0;
      check("flush.hs", 64'(hs), 64'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk_i);
        check_idle("flushreq");
        next_cycle();
      end
      quiet();
      return;
    end
    check("req.hs", 64'(hs), 64'd1);
    if (fmode == 2) wb_valid_i = 0;

    for (int i = 0; i < wl; i++) begin
      csr_resp_valid_i = (i == k);
      csr_resp_data_i  = (i == k) ? rdv : {$urandom, $urandom};
      csr_resp_xcpt_i  = (i == k) ? rx : 1'b0;
      flush_i = (fmode == 3) && (i == fidx);
      @(negedge clk_i);
      check("wait.stall", 64'(wb_stall_o), 64'd1);
      check("wait.valid", 64'(csr_req_valid_o), 64'd0);
      check("wait.done",  64'(wb_csr_done_o), 64'd0);
      next_cycle();
      if (flush_i) wb_valid_i = 0;
    end
    flush_i = 0;
    csr_resp_valid_i = ($urandom_range(0, 1) == 1);
    csr_resp_data_i  = {$urandom, $urandom};

    @(negedge clk_i);
    check("done.pulse", 64'(wb_csr_done_o), 64'(!discard));
    check("done.stall", 64'(wb_stall_o), 64'd0);
    check("done.valid", 64'(csr_req_valid_o), 64'd0);
    if (!discard) begin
      check("done.rdata", wb_csr_rdata_o, timeout ? 64'd0 : rdv);
      check("done.xcpt",  64'(wb_csr_xcpt_o), timeout ? 64'd1 : 64'(rx));
    end
    next_cycle();
    quiet();
    @(negedge clk_i);
    check_idle("after");
    next_cycle();
  endtask

  initial begin
    quiet();
    rst_i = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_idle("rst");
    check("rst.retire", 64'(retire_o), 64'd0);
    check("rst.rdata",  wb_csr_rdata_o, 64'd0);
    check("rst.xcpt",   64'(wb_csr_xcpt_o), 64'd0);
    check("rst.addr",   64'(csr_req_addr_o), 64'd0);
    check("rst.cmd",    64'(csr_req_cmd_o), 64'd0);
    check("rst.data",   csr_req_data_o, 64'd0);
    check("rst.pc",     csr_req_pc_o, 64'd0);
    rst_i = 0;
    next_cycle();

    run_csr(36, 3, 64'hDEAD, 12'h300, 64'h8000_0000, 0, 0, 0, 0, 64'h1234, 0);
    run_csr(37, 0, 64'hFFFF, 12'h341, 64'h8000_0004, 0, 1, 0, 0, 64'h55, 0);
    run_csr(41, 5, 64'hABCD, 12'h304, 64'h8000_0008, 1, 0, 0, 0, 64'h77, 1);
    run_csr(38, 7, 64'hF0F0, 12'h305, 64'h8000_000C, 4, 2, 0, 0, 64'h99, 0);
    run_csr(36, 1, 64'h1, 12'h340, 64'h8000_0010, 3, 0, 1, 2, 64'h0, 0);
    run_csr(37, 2, 64'h2, 12'h342, 64'h8000_0014, 0, 3, 3, 1, 64'h33, 0);
    run_csr(39, 9, 64'h0, 12'h343, 64'h8000_0018, 0, 20, 0, 0, 64'h44, 0);
    run_csr(40, 4, 64'h0, 12'h344, 64'h8000_001C, 2, TO - 2, 0, 0, 64'h66, 1);
    run_csr(23, 0, 64'h5, 12'h000, 64'h8000_0020, 1, 1, 2, 0, 64'h88, 0);

    wb_valid_i = 1; wb_instr_type_i = 7'd1;
    @(negedge clk_i);
    check("add.retire", 64'(retire_o), 64'd1);
    check_idle("add");
    next_cycle();
    wb_xcpt_i = 1;
    @(negedge clk_i);
    check("addx.retire", 64'(retire_o), 64'd0);
    check_idle("addx");
    next_cycle();
    quiet();

    for (int n = 0; n < 40; n++) begin
      int rdly, k, fm, fidx, wl;
      filler(int'($urandom_range(0, 3)));
      rdly = int'($urandom_range(0, 4));
      k    = int'($urandom_range(0, 9));
      wl   = (k < TO - 1) ? k + 1 : TO - 1;
      fm   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      fidx = (fm == 1) ? int'($urandom_range(0, rdly)) :
             (fm == 3) ? int'($urandom_range(0, wl - 1)) : 0;
      run_csr(rand_csr_type(), int'($urandom_range(0, 31)), {$urandom, $urandom},
              12'($urandom), {$urandom, $urandom}, rdly, k, fm, fidx,
              {$urandom, $urandom}, bit'($urandom_range(0, 1)));
    end

    // Reset while waiting for a response.
    wb_valid_i = 1; wb_instr_type_i = 7'd36; wb_rs1_i = 5'd1; wb_rs1_data_i = 64'hCAFE;
    wb_csr_addr_i = 12'h300; wb_pc_i = 64'h100;
    next_cycle();
    csr_req_ready_i = 1;
    next_cycle();
    csr_req_ready_i = 0;
    next_cycle();
    wb_valid_i = 0;
    rst_i = 1;
    #1;
    check_idle("rstwait");
    check("rstwait.addr",  64'(csr_req_addr_o), 64'd0);
    check("rstwait.data",  csr_req_data_o, 64'd0);
    check("rstwait.pc",    csr_req_pc_o, 64'd0);
    check("rstwait.cmd",   64'(csr_req_cmd_o), 64'd0);
    check("rstwait.rdata", wb_csr_rdata_o, 64'd0);
    check("rstwait.xcpt",  64'(wb_csr_xcpt_o), 64'd0);
    @(negedge clk_i);
    rst_i = 0;
    csr_resp_valid_i = 1; csr_resp_data_i = 64'h1234;
    next_cycle();
    csr_resp_valid_i = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check_idle("postrst");
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
